// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: lets the core LSU (M0) and the debug/loader port (M1)
// share the byte-lane data RAM. The RAM read port and write port are each
// given their own round-robin arbiter, so one read and one write can issue in
// the same cycle. Accesses that fall outside the RAM window never reach the
// RAM and are answered with an error response instead. A write that hits the
// same word as a read granted in the same cycle is merged into that read's
// returned data, because the RAM itself returns the old word.
module dram_port_arbiter #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] WIN_MASK  = 32'hFFFF_C000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_be,
  input  logic [3:0]  m1_be,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic        ram_ren,
  output logic [31:0] ram_r_addr,
  input  logic [31:0] ram_r_data
);

  // True when the byte address falls inside the RAM window.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr & WIN_MASK) == BASE_ADDR;
  endfunction

  // Replace the lanes of base selected by be with the matching lanes of fwd.
  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] fwd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = fwd[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = base[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // Request classification
  logic m0_rd_s, m1_rd_s, m0_wr_s, m1_wr_s;
  assign m0_rd_s = m0_req & ~m0_we;
  assign m1_rd_s = m1_req & ~m1_we;
  assign m0_wr_s = m0_req &  m0_we;
  assign m1_wr_s = m1_req &  m1_we;

  // Round-robin pointers: 0 = M0 preferred, 1 = M1 preferred
  logic rd_ptr_q, rd_ptr_d;
  logic wr_ptr_q, wr_ptr_d;

  logic rd_gnt0_s, rd_gnt1_s, wr_gnt0_s, wr_gnt1_s;

  // Selected-request views of each port
  logic        r_any_s, r_inwin_s, r_ok_s;
  logic [31:0] r_addr_s;
  logic        w_any_s, w_inwin_s, w_ok_s;
  logic [31:0] w_addr_s, w_data_s;
  logic [3:0]  w_be_s;
  logic        fwd_s;

  // Pending read response and write error state
  logic        pend_vld_q, pend_vld_d;
  logic        pend_owner_q, pend_owner_d;
  logic        pend_oob_q, pend_oob_d;
  logic [RAM_AW-1:0] pend_widx_q, pend_widx_d;
  logic [3:0]  fwd_be_q, fwd_be_d;
  logic [31:0] fwd_data_q, fwd_data_d;
  logic        werr0_q, werr0_d, werr1_q, werr1_d;
  logic [31:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [31:0] resp_data_s;

  // Per-port arbitration and pointer update: pointer moves to the loser of a conflict
  always_comb begin
    rd_gnt0_s = 1'b0;
    rd_gnt1_s = 1'b0;
    wr_gnt0_s = 1'b0;
    wr_gnt1_s = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (m0_rd_s && m1_rd_s) begin
      rd_gnt0_s = ~rd_ptr_q;
      rd_gnt1_s =  rd_ptr_q;
      rd_ptr_d  = ~rd_ptr_q;
    end else begin
      rd_gnt0_s = m0_rd_s;
      rd_gnt1_s = m1_rd_s;
    end
    if (m0_wr_s && m1_wr_s) begin
      wr_gnt0_s = ~wr_ptr_q;
      wr_gnt1_s =  wr_ptr_q;
      wr_ptr_d  = ~wr_ptr_q;
    end else begin
      wr_gnt0_s = m0_wr_s;
      wr_gnt1_s = m1_wr_s;
    end
  end

  // Select the granted request on each RAM port and drive the RAM
  always_comb begin
    r_any_s    = rd_gnt0_s | rd_gnt1_s;
    r_addr_s   = rd_gnt1_s ? m1_addr : m0_addr;
    r_inwin_s  = in_window(r_addr_s);
    r_ok_s     = r_any_s & r_inwin_s;
    w_any_s    = wr_gnt0_s | wr_gnt1_s;
    w_addr_s   = wr_gnt1_s ? m1_addr  : m0_addr;
    w_data_s   = wr_gnt1_s ? m1_wdata : m0_wdata;
    w_be_s     = wr_gnt1_s ? m1_be    : m0_be;
    w_inwin_s  = in_window(w_addr_s);
    w_ok_s     = w_any_s & w_inwin_s;
    ram_ren    = r_ok_s;
    ram_r_addr = r_ok_s ? r_addr_s : 32'h0000_0000;
    ram_wen    = w_ok_s ? w_be_s   : 4'b0000;
    ram_w_addr = w_ok_s ? w_addr_s : 32'h0000_0000;
    ram_w_data = w_ok_s ? w_data_s : 32'h0000_0000;
    fwd_s      = r_ok_s & w_ok_s &
                 (r_addr_s[RAM_AW+1:2] == w_addr_s[RAM_AW+1:2]);
  end

  // Next state of the pending read descriptor and write error flags
  always_comb begin
    pend_vld_d   = r_any_s;
    pend_owner_d = rd_gnt1_s;
    pend_oob_d   = r_any_s & ~r_inwin_s;
    pend_widx_d  = r_addr_s[RAM_AW+1:2];
    fwd_be_d     = fwd_s ? w_be_s   : 4'b0000;
    fwd_data_d   = fwd_s ? w_data_s : 32'h0000_0000;
    werr0_d      = wr_gnt0_s & ~in_window(m0_addr);
    werr1_d      = wr_gnt1_s & ~in_window(m1_addr);
  end

  // Response outputs: merged read data on rvalid, held data otherwise
  always_comb begin
    m0_gnt      = rd_gnt0_s | wr_gnt0_s;
    m1_gnt      = rd_gnt1_s | wr_gnt1_s;
    resp_data_s = pend_oob_q ? 32'h0000_0000
                             : merge_lanes(ram_r_data, fwd_data_q, fwd_be_q);
    m0_rvalid   = pend_vld_q & ~pend_owner_q;
    m1_rvalid   = pend_vld_q &  pend_owner_q;
    m0_rdata    = m0_rvalid ? resp_data_s : hold0_q;
    m1_rdata    = m1_rvalid ? resp_data_s : hold1_q;
    m0_err      = (m0_rvalid & pend_oob_q) | werr0_q;
    m1_err      = (m1_rvalid & pend_oob_q) | werr1_q;
    hold0_d     = m0_rdata;
    hold1_d     = m1_rdata;
  end

  // State registers; reset drops any in-flight read and re-prefers M0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_oob_q   <= 1'b0;
      pend_widx_q  <= '0;
      fwd_be_q     <= 4'b0000;
      fwd_data_q   <= 32'h0000_0000;
      werr0_q      <= 1'b0;
      werr1_q      <= 1'b0;
      hold0_q      <= 32'h0000_0000;
      hold1_q      <= 32'h0000_0000;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pend_vld_q   <= pend_vld_d;
      pend_owner_q <= pend_owner_d;
      pend_oob_q   <= pend_oob_d;
      pend_widx_q  <= pend_widx_d;
      fwd_be_q     <= fwd_be_d;
      fwd_data_q   <= fwd_data_d;
      werr0_q      <= werr0_d;
      werr1_q      <= werr1_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

  // The registered word index is only meaningful alongside a pending read;
  // it is kept so the descriptor is complete for debug visibility.
  logic widx_unused_s;
  assign widx_unused_s = ^pend_widx_q;

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the byte-lane data RAM between two masters: M0 is the core load/store unit and M1 is the debug/loader port.
- The RAM's read port and write port are arbitrated independently, so one read and one write can proceed in the same cycle.
- Out-of-window accesses are filtered and flagged with an error response.
- Read data comes back one cycle after the grant; same-cycle write data is forwarded into that returned data.
- The block sits between the LSU/debug module and the data RAM.

Parameters:
- RAM_AW, 12, word-address width of the RAM (word index = addr[RAM_AW+1:2]).
- BASE_ADDR, 32'h1000_0000, base of the RAM window.
- WIN_MASK, 32'hFFFF_C000, mask applied to addr; in window when (addr & WIN_MASK) == BASE_ADDR.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1 each  access request, held until granted
- m0_we, m1_we  in  1 each  1 = write, 0 = read
- m0_addr, m1_addr  in  32 each  byte address
- m0_wdata, m1_wdata  in  32 each  write data, lane-aligned
- m0_be, m1_be  in  4 each  byte enables for writes
- m0_gnt, m1_gnt  out  1 each  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1 each  read response valid
- m0_rdata, m1_rdata  out  32 each  read response data
- m0_err, m1_err  out  1 each  out-of-window response; pulses with rvalid for reads, the cycle after grant for writes
- ram_wen  out  4  RAM byte write enables
- ram_w_addr  out  32  RAM write address
- ram_w_data  out  32  RAM write data
- ram_ren  out  1  RAM read enable
- ram_r_addr  out  32  RAM read address
- ram_r_data  in  32  RAM read data, valid one cycle after ram_ren

Behaviour:
- Reset (rst=0, asynchronous):
  - all rvalid and err outputs = 0; all rdata = 0.
  - Both round-robin pointers point at M0 (M0 wins the first conflict).
  - The pending-read register is cleared; any in-flight read is dropped with no rvalid.
- Classification: each request is a read (we=0) or a write (we=1). Reads compete only for the read port; writes compete only for the write port.
- Per-port arbitration, same rule for read and write ports:
  - One requester of that type: it is granted.
  - Both: the master indicated by the port's pointer is granted.
  - After a granted conflict the pointer moves to the loser. With no conflict the pointer is unchanged.
  - A master whose request is not granted holds its signals stable; gnt=0.
  - Each master issues at most one request per cycle, so a master gets at most one grant per cycle.
- Granted write:
  - In window: ram_wen = be, ram_w_addr = addr, ram_w_data = wdata.
  - Out of window: ram_wen = 0 and err pulses the next cycle.
  - With no granted write, ram_wen = 0.
- Granted read:
  - In window: ram_ren = 1, ram_r_addr = addr.
  - In the same cycle, register {owner, oob flag, word index, fwd_be, fwd_data}.
  - Next cycle: owner's rvalid = 1, rdata = ram_r_data with the lanes in fwd_be replaced by fwd_data. Lanes are merged per byte.
  - Out of window: ram_ren = 0; next cycle rvalid = 1, err = 1, rdata = 0.
- Forwarding: if a write and a read are granted in the same cycle, both in window, with the same word index, then fwd_be = the write's be and fwd_data = its wdata; otherwise fwd_be = 0.
- Throughput:
  - A back-to-back read every cycle is sustained; rvalid follows each grant by exactly 1 cycle.
  - rdata holds its last value while rvalid=0.
- Same-master read and write in consecutive cycles: the read sees the earlier write, because the RAM has completed it.

Test Plan:
- Reset then M0 write addr 0x1000_0004, be=4'b1111, wdata=0xDEADBEEF; next cycle M0 read same addr -> m0_gnt=1 both cycles; m0_rvalid=1 two cycles after the write grant (one cycle after the read grant) with m0_rdata=0xDEADBEEF, m0_err=0.
- M0 and M1 both read in window every cycle for 4 cycles -> grants alternate M0, M1, M0, M1; each rvalid arrives exactly 1 cycle after its grant to the correct master.
- Same cycle: M1 writes 0x1000_0010 be=4'b0010 wdata=0x0000_AB00; M0 reads 0x1000_0010 (old word 0x1122_3344) -> both granted; next cycle m0_rdata=0x1122_AB44.
- M1 read at 0x2000_0000 -> ram_ren=0; next cycle m1_rvalid=1, m1_err=1, m1_rdata=0. M1 write at the same address -> ram_wen=0, m1_err pulses the next cycle.
- M0 read granted, then rst asserted low before the next edge -> m0_rvalid stays 0; after release, the first conflicting read is granted to M0.
- Held request: M1 write loses a conflict -> m1_gnt=0, signals held stable; M1 is granted the next cycle with ram_wen = m1_be.
